// File: rtl/audiosystem_vga_timing_pkg.sv
// Shared 640x480@60 timing constants, polarities and FSM encoding for the VGA timing stage.
package audiosystem_vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOT_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOT_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic HS_POL_DEF = 1'b0;
  localparam logic VS_POL_DEF = 1'b0;

  localparam int unsigned PIX_LAT_DEF = 2;
  localparam int unsigned CW_DEF      = 10;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } vga_state_e;

  // Half-open window test lo <= val < lo + len.
  function automatic logic in_window(int unsigned val, int unsigned lo, int unsigned len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/audiosystem_vga_timing_pipe_dly.sv
// Fixed-depth shift register with synchronous reset and clear; aligns sync/blank with pixel data.
module audiosystem_vga_timing_pipe_dly #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/audiosystem_vga_timing.sv
// VGA timing generator: lock-gated run FSM, h/v counters, pixel request and aligned DAC outputs.
module audiosystem_vga_timing
  import audiosystem_vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter logic        HS_POL   = HS_POL_DEF,
  parameter logic        VS_POL   = VS_POL_DEF,
  parameter int unsigned PIX_LAT  = PIX_LAT_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic [23:0]   in_rgb,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_req,
  output logic          frame_start,
  output logic          active,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic          vga_sync_n,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((((H_TOT - 1) >> CW) != 0) || (((V_TOT - 1) >> CW) != 0)) begin : gen_cw_too_small
    $error("CW too narrow for H_TOT-1 / V_TOT-1");
  end
  if ((PIX_LAT < 1) || (PIX_LAT > 8)) begin : gen_bad_pix_lat
    $error("PIX_LAT must be 1..8");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);

  // Clock-domain entry for the PLL lock flag.
  logic lk_meta_q, lk_s_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_s_q    <= lk_meta_q;
    end
  end

  vga_state_e    state_q, state_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          run_ok;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      StIdle: begin
        h_d = '0;
        v_d = '0;
        if (lk_s_q) state_d = StRun;
      end
      StRun: begin
        if (!lk_s_q) begin
          state_d = StIdle;
          h_d     = '0;
          v_d     = '0;
        end else if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Any lock loss clears the whole pipeline on the same edge the FSM drops to idle.
  assign run_ok = (state_q == StRun) && lk_s_q;

  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic          req_q, req_d, fs_q, fs_d, hs_act_q, hs_act_d, vs_act_q, vs_act_d;

  always_comb begin
    pix_x_d  = '0;
    pix_y_d  = '0;
    req_d    = 1'b0;
    fs_d     = 1'b0;
    hs_act_d = 1'b0;
    vs_act_d = 1'b0;
    if (run_ok) begin
      pix_x_d  = h_q;
      pix_y_d  = v_q;
      req_d    = in_window(32'(h_q), 0, H_ACTIVE) && in_window(32'(v_q), 0, V_ACTIVE);
      fs_d     = (h_q == '0) && (v_q == '0);
      hs_act_d = in_window(32'(h_q), H_ACTIVE + H_FP, H_SYNC);
      vs_act_d = in_window(32'(v_q), V_ACTIVE + V_FP, V_SYNC);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      req_q    <= 1'b0;
      fs_q     <= 1'b0;
      hs_act_q <= 1'b0;
      vs_act_q <= 1'b0;
    end else begin
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      req_q    <= req_d;
      fs_q     <= fs_d;
      hs_act_q <= hs_act_d;
      vs_act_q <= vs_act_d;
    end
  end

  logic [2:0] dly_q;

  audiosystem_vga_timing_pipe_dly #(
    .WIDTH (3),
    .DEPTH (PIX_LAT)
  ) u_pipe_dly (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (!run_ok),
    .d_i    ({hs_act_q, vs_act_q, req_q}),
    .q_o    (dly_q)
  );

  logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    hs_d      = ~HS_POL;
    vs_d      = ~VS_POL;
    blank_n_d = 1'b0;
    rgb_d     = '0;
    if (run_ok) begin
      hs_d      = dly_q[2] ? HS_POL : ~HS_POL;
      vs_d      = dly_q[1] ? VS_POL : ~VS_POL;
      blank_n_d = dly_q[0];
      if (dly_q[0]) rgb_d = in_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_req     = req_q;
  assign frame_start = fs_q;
  assign active      = (state_q == StRun);
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule
